// File: rtl/bpu_pkg.sv
// Shared types and helpers for the tournament branch predictor.
// Counter encodings, meta field layout and sweep FSM states.
package bpu_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // metaD/metaM = {ghr_snap, g_pred, l_pred, choose_local}
  localparam int META_C   = 0;
  localparam int META_L   = 1;
  localparam int META_G   = 2;
  localparam int META_GHR = 3;

  typedef enum logic {INIT, RUN} bpu_state_e;

  function automatic int meta_w(input int ghrW);
    return ghrW + 3;
  endfunction

  function automatic logic [1:0] sat_step(
    input logic [1:0] cnt,
    input logic       taken
  );
    if (taken)
      return (cnt == ST) ? ST : cnt + 2'd1;
    else
      return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_ctr_table.sv
// Array of 2-bit saturating counters.
// One async read port, one write port shared by init sweep and training.
module bpu_ctr_table #(
  parameter int         IDX_W = 8,
  parameter logic [1:0] INIT  = bpu_pkg::WT
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCnt,
  input  logic             initWe,
  input  logic             we,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             taken
);

  logic [1:0] mem [2**IDX_W];

  assign rdCnt = mem[rdIdx];

  always_ff @(posedge clk) begin
    if (initWe)
      mem[wrIdx] <= INIT;
    else if (we)
      mem[wrIdx] <= bpu_pkg::sat_step(mem[wrIdx], taken);
  end

endmodule

// File: rtl/tournament_bpu.sv
// Tournament predictor: gshare vs per-PC local history, per-PC chooser.
// Tables are cleared by a post-reset sweep; GHR is repaired on mispredict.
module tournament_bpu
  import bpu_pkg::*;
#(
  parameter int GHR_W     = 8,
  parameter int LHR_W     = 6,
  parameter int BHT_IDX_W = 10,
  parameter int CH_IDX_W  = 10,
  parameter int PC_LSB    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pcF,
  input  logic                branchF,
  input  logic                stallD,
  input  logic                flushD,
  input  logic                branchD,
  output logic                pred_takeD,
  output logic [GHR_W+2:0]    metaD,
  input  logic                branchM,
  input  logic [31:0]         pcM,
  input  logic                actual_takeM,
  input  logic [GHR_W+2:0]    metaM,
  input  logic                errorM,
  output logic                init_busy
);

  localparam int S1 = (GHR_W > BHT_IDX_W) ? GHR_W : BHT_IDX_W;
  localparam int S2 = (CH_IDX_W > LHR_W) ? CH_IDX_W : LHR_W;
  localparam int S  = (S1 > S2) ? S1 : S2;
  localparam int MW = meta_w(GHR_W);

  bpu_state_e state, nextState;
  logic [S-1:0] sweepIdx;
  logic run;

  always_ff @(posedge clk) begin
    if (!rst) state <= INIT;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      INIT: if (sweepIdx == '1) nextState = RUN;
      RUN:  nextState = RUN;
    endcase
  end

  always_comb begin
    init_busy = (state == INIT);
    run       = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst)          sweepIdx <= '0;
    else if (init_busy) sweepIdx <= sweepIdx + S'(1);
  end

  logic [GHR_W-1:0] ghr, ghrNext, snapM;
  logic [1:0] gCnt, lCnt, cCnt;
  logic gF, lF, cF, predF;
  logic [LHR_W-1:0] bht [2**BHT_IDX_W];
  logic [LHR_W-1:0] lhrF, lhrM;
  logic [BHT_IDX_W-1:0] bIdxF, bIdxM;
  logic repair, doShift;
  logic gM, lM, chWe;

  assign bIdxF = pcF[PC_LSB +: BHT_IDX_W];
  assign bIdxM = pcM[PC_LSB +: BHT_IDX_W];
  assign lhrF  = bht[bIdxF];
  assign lhrM  = bht[bIdxM];
  assign snapM = metaM[META_GHR +: GHR_W];
  assign gM    = metaM[META_G];
  assign lM    = metaM[META_L];

  assign gF    = gCnt[1];
  assign lF    = lCnt[1];
  assign cF    = cCnt[1];
  assign predF = cF ? lF : gF;

  assign repair  = run & errorM & branchM;
  assign doShift = run & branchF & ~stallD & ~repair;

  always_comb begin
    ghrNext = ghr;
    unique case (1'b1)
      repair:  ghrNext = {snapM[GHR_W-2:0], actual_takeM};
      doShift: ghrNext = {ghr[GHR_W-2:0], predF};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) ghr <= '0;
    else      ghr <= ghrNext;
  end

  // Chooser only moves when exactly one component was right
  assign chWe = run & branchM &
    ((gM == actual_takeM) != (lM == actual_takeM));

  bpu_ctr_table #(.IDX_W(GHR_W), .INIT(WT)) gpht (
    .clk   (clk),
    .rdIdx (ghr ^ pcF[PC_LSB +: GHR_W]),
    .rdCnt (gCnt),
    .initWe(init_busy),
    .we    (run & branchM),
    .wrIdx (init_busy ? sweepIdx[GHR_W-1:0]
                      : snapM ^ pcM[PC_LSB +: GHR_W]),
    .taken (actual_takeM)
  );

  bpu_ctr_table #(.IDX_W(LHR_W), .INIT(WT)) lpht (
    .clk   (clk),
    .rdIdx (lhrF),
    .rdCnt (lCnt),
    .initWe(init_busy),
    .we    (run & branchM),
    .wrIdx (init_busy ? sweepIdx[LHR_W-1:0] : lhrM),
    .taken (actual_takeM)
  );

  bpu_ctr_table #(.IDX_W(CH_IDX_W), .INIT(WNT)) cht (
    .clk   (clk),
    .rdIdx (pcF[PC_LSB +: CH_IDX_W]),
    .rdCnt (cCnt),
    .initWe(init_busy),
    .we    (chWe),
    .wrIdx (init_busy ? sweepIdx[CH_IDX_W-1:0]
                      : pcM[PC_LSB +: CH_IDX_W]),
    .taken (lM == actual_takeM)
  );

  always_ff @(posedge clk) begin
    if (init_busy)
      bht[sweepIdx[BHT_IDX_W-1:0]] <= '0;
    else if (branchM)
      bht[bIdxM] <= {lhrM[LHR_W-2:0], actual_takeM};
  end

  logic [MW-1:0] metaReg;

  always_ff @(posedge clk) begin
    if (!rst)
      metaReg <= '0;
    else if (init_busy || flushD)
      metaReg <= '0;
    else if (!stallD)
      metaReg <= {ghr, gF, lF, cF};
  end

  assign metaD = metaReg;
  assign pred_takeD = branchD & (metaReg[META_C] ? metaReg[META_L]
                                                 : metaReg[META_G]);

  logic unused;
  assign unused = ^{pcF, pcM, metaM, gCnt[0], lCnt[0], cCnt[0]};

endmodule

// File: tb/tb_tournament_bpu.sv
// Directed bench for tournament_bpu with default parameters.
// Expected values are hand-derived from the table/GHR state at each step.
module tb_tournament_bpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcF = '0;
  logic        branchF = 1'b0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        branchD = 1'b1;
  logic        pred_takeD;
  logic [10:0] metaD;
  logic        branchM = 1'b0;
  logic [31:0] pcM = '0;
  logic        actual_takeM = 1'b0;
  logic [10:0] metaM = '0;
  logic        errorM = 1'b0;
  logic        init_busy;

  int checks = 0;
  int errors = 0;
  int n, bad;
  logic [10:0] saved;
  bit act;

  tournament_bpu dut (
    .clk(clk), .rst(rst),
    .pcF(pcF), .branchF(branchF),
    .stallD(stallD), .flushD(flushD),
    .branchD(branchD),
    .pred_takeD(pred_takeD), .metaD(metaD),
    .branchM(branchM), .pcM(pcM),
    .actual_takeM(actual_takeM), .metaM(metaM),
    .errorM(errorM), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitInit(output int cnt, output int badCnt);
    cnt = 0;
    badCnt = 0;
    while (init_busy === 1'b1 && cnt < 3000) begin
      if (pred_takeD !== 1'b0 || metaD !== 11'h0) badCnt++;
      cnt++;
      tick();
    end
  endtask

  task automatic mIdle();
    branchM = 0; errorM = 0; metaM = '0;
  endtask

  initial begin
    // Reset and full sweep, with branch traffic during INIT
    rst = 0; branchF = 1; branchD = 1; pcF = 32'h100;
    tick();
    chk("rst_busy", init_busy, 1);
    chk("rst_meta", metaD, 0);
    rst = 1;
    waitInit(n, bad);
    chk("init_len", n, 1024);
    chk("init_quiet", bad, 0);

    // First branch after init: global WT -> taken
    pcF = 32'h100; branchF = 1;
    tick();
    chk("first_meta", metaD, 11'h006);
    chk("first_pred", pred_takeD, 1);

    // pc 0x100 not-taken twice, repairing GHR to 0 each time
    branchF = 0; branchM = 1; errorM = 1; pcM = 32'h100;
    metaM = 11'h006; actual_takeM = 0;
    tick();
    mIdle(); branchF = 1; pcF = 32'h100;
    tick();
    chk("nt1_meta", metaD, 11'h000);
    branchF = 0; branchM = 1; errorM = 1; pcM = 32'h100;
    metaM = 11'h006; actual_takeM = 0;
    tick();
    mIdle(); branchF = 1; pcF = 32'h100;
    tick();
    chk("nt2_meta", metaD, 11'h000);
    chk("nt2_pred", pred_takeD, 0);
    // One taken: GPHT 00->01 still predicts 0; BHT now 1 -> fresh LPHT
    branchF = 0; branchM = 1; pcM = 32'h100;
    metaM = 11'h000; actual_takeM = 1;
    tick();
    mIdle(); branchF = 1; pcF = 32'h100;
    tick();
    chk("sat_meta", metaD, 11'h002);
    chk("sat_pred", pred_takeD, 0);

    // Three speculative taken predictions, then repair
    pcF = 32'h300;
    tick();
    chk("spec1", metaD, 11'h004);
    tick();
    chk("spec2", metaD, 11'h00C);
    tick();
    chk("spec3", metaD, 11'h01C);
    branchM = 1; errorM = 1; pcM = 32'h300;
    metaM = 11'h028; actual_takeM = 0;
    tick();
    chk("err_old", metaD, 11'h03C);
    mIdle(); pcF = 32'h0;
    tick();
    chk("repair", metaD, 11'h054);

    // Force GHR to 0, then stall 3 cycles with branchF high
    branchF = 0; branchM = 1; errorM = 1; pcM = 32'h3FC;
    metaM = 11'h000; actual_takeM = 0;
    tick();
    mIdle(); branchF = 1; pcF = 32'h0;
    tick();
    chk("pre_stall", metaD, 11'h004);
    stallD = 1; branchD = 0;
    tick();
    chk("stall1", metaD, 11'h004);
    chk("stall1_brD", pred_takeD, 0);
    branchD = 1;
    tick();
    chk("stall2", metaD, 11'h004);
    chk("stall2_pred", pred_takeD, 1);
    flushD = 1;
    tick();
    chk("flush_meta", metaD, 11'h000);
    chk("flush_pred", pred_takeD, 0);
    stallD = 0; flushD = 0;
    tick();
    chk("post_stall", metaD, 11'h00C);

    // Alternating T/N at pc 0x200 with fixed GHR context
    branchF = 0;
    for (int i = 0; i < 40; i++) begin
      act = (i % 2 == 0);
      mIdle(); pcF = 32'h200;
      tick();
      saved = metaD;
      if (i >= 12) begin
        chk("alt_pred", pred_takeD, act);
        chk("alt_choose", metaD[0], 1);
      end
      branchM = 1; pcM = 32'h200;
      metaM = saved; actual_takeM = act;
      tick();
    end
    // Global right, local wrong once: saturated chooser stays local
    branchM = 1; pcM = 32'h200;
    metaM = 11'h01D; actual_takeM = 1;
    tick();
    mIdle(); pcF = 32'h200;
    tick();
    chk("ch_sat", metaD[0], 1);

    // Reset at sweep index 300 restarts the full sweep
    branchF = 1; pcF = 32'h100;
    rst = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 300; i++) tick();
    chk("mid_busy", init_busy, 1);
    rst = 0;
    tick();
    rst = 1;
    waitInit(n, bad);
    chk("reinit_len", n, 1024);
    chk("reinit_quiet", bad, 0);
    pcF = 32'h100;
    tick();
    chk("reinit_meta", metaD, 11'h006);
    chk("reinit_pred", pred_takeD, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
